// File: rtl/hc32_tester_if.sv
// rtl/hc32_tester_if.sv - Control, stimulus and result signals of the quad OR-gate tester.
interface hc32_tester_if;
    logic       start;
    logic [3:0] a_drv;
    logic [3:0] b_drv;
    logic [3:0] y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;

    modport master (
        output start,
        output y_in,
        input  a_drv,
        input  b_drv,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask
    );

    modport slave (
        input  start,
        input  y_in,
        output a_drv,
        output b_drv,
        output busy,
        output done,
        output pass,
        output fail_mask
    );
endinterface

// File: rtl/hc32_tester.sv
// rtl/hc32_tester.sv - Exhaustive 4-vector tester for a quad 2-input OR gate package.
// Optional HC32_SYNC_EN adds a 2-flop synchronizer on y_in and lengthens settle by 2 cycles.
module hc32_tester #(
    parameter int SETTLE_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    hc32_tester_if.slave bus
);
`ifdef HC32_SYNC_EN
    localparam int S_EFF = SETTLE_CYCLES + 2;
`else
    localparam int S_EFF = SETTLE_CYCLES;
`endif
    localparam logic [8:0] CNT_LAST = 9'(S_EFF - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;

    state_t     state;
    logic [1:0] v;
    logic [8:0] cnt;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] fail_q;
    logic [3:0] y_cmp;
    logic [3:0] new_fail;
    logic [1:0] v_nxt;

`ifdef HC32_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= bus.y_in;
            sync2 <= sync1;
        end
    end

    assign y_cmp = sync2;
`else
    assign y_cmp = bus.y_in;
`endif

    // Expected OR output for vector v is simply v[1]|v[0] on every gate.
    assign new_fail = fail_q | (y_cmp ^ {4{v[1] | v[0]}});
    assign v_nxt    = v + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            v      <= 2'd0;
            cnt    <= 9'd0;
            a_q    <= 4'b0;
            b_q    <= 4'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 4'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    a_q    <= 4'b0;
                    b_q    <= 4'b0;
                    if (bus.start) begin
                        state  <= SETTLE;
                        v      <= 2'd0;
                        cnt    <= 9'd0;
                        fail_q <= 4'b0;
                        pass_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= 9'd0;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end
                CHECK: begin
                    fail_q <= new_fail;
                    if (v == 2'd3) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        pass_q <= (new_fail == 4'b0);
                        a_q    <= 4'b0;
                        b_q    <= 4'b0;
                    end else begin
                        state <= SETTLE;
                        v     <= v_nxt;
                        a_q   <= {4{v_nxt[1]}};
                        b_q   <= {4{v_nxt[0]}};
                    end
                end
                FINISH: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_drv     = a_q;
    assign bus.b_drv     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;
endmodule

// File: tb/tb_hc32_tester.sv
// tb/tb_hc32_tester.sv - Directed checks of hc32_tester against healthy and faulty OR-gate models.
module tb_hc32_tester;
`ifdef HC32_SYNC_EN
    localparam int ADD = 2;
`else
    localparam int ADD = 0;
`endif
    localparam int S8  = 8 + ADD;
    localparam int S12 = 12 + ADD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st  = 1'b0;
    int   sel  = 0;
    int   mode = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [9:0] dl8  = '0;
    logic [9:0] dl12 = '0;

    hc32_tester_if if8 ();
    hc32_tester_if if12 ();

    hc32_tester #(.SETTLE_CYCLES(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    hc32_tester #(.SETTLE_CYCLES(12)) dut12 (.clk(clk), .rst(rst), .bus(if12.slave));

    always #5 clk = ~clk;

    // Gate model: 1 = gate2 stuck-at-0, 2 = gate0 stuck-at-1, 3 = gate3 lags 10 cycles.
    function automatic logic [3:0] gate(input logic [3:0] ab, input logic lag3, input int m);
        logic [3:0] y;
        y = ab;
        case (m)
            1: y[2] = 1'b0;
            2: y[0] = 1'b1;
            3: y[3] = lag3;
            default: ;
        endcase
        return y;
    endfunction

    always_ff @(posedge clk) begin
        dl8  <= {dl8[8:0], if8.a_drv[3] | if8.b_drv[3]};
        dl12 <= {dl12[8:0], if12.a_drv[3] | if12.b_drv[3]};
    end

    assign if8.y_in   = gate(if8.a_drv | if8.b_drv, dl8[9], mode);
    assign if12.y_in  = gate(if12.a_drv | if12.b_drv, dl12[9], mode);
    assign if8.start  = (sel == 0) && st;
    assign if12.start = (sel == 1) && st;

    logic [3:0] m_a, m_b, m_fail;
    logic       m_busy, m_done, m_pass;
    assign m_a    = (sel == 1) ? if12.a_drv     : if8.a_drv;
    assign m_b    = (sel == 1) ? if12.b_drv     : if8.b_drv;
    assign m_fail = (sel == 1) ? if12.fail_mask : if8.fail_mask;
    assign m_busy = (sel == 1) ? if12.busy      : if8.busy;
    assign m_done = (sel == 1) ? if12.done      : if8.done;
    assign m_pass = (sel == 1) ? if12.pass      : if8.pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         done_cnt, done_cyc, busy_first, busy_last, busy_cnt;
    logic [3:0] a_at [4];
    logic [3:0] b_at [4];
    logic [15:0] snap;

    // Pulse start in cycle 0, then watch 80 cycles sampling on the falling edge.
    task automatic run(input int s, input int hold_lo, input int hold_hi,
                       input int rst_at, input int fin_start);
        int se;
        se = (s == 1) ? S12 : S8;
        sel = s;
        done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1; busy_cnt = 0;
        snap = 16'hdead;
        @(negedge clk);
        st = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (m_done) begin done_cnt++; done_cyc = k; end
            if (m_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            for (int j = 0; j < 4; j++)
                if (k == (j + 1) * (se + 1)) begin a_at[j] = m_a; b_at[j] = m_b; end
            if (k == rst_at + 1)
                snap = {m_a, m_b, m_busy, m_done, m_pass, 1'b0, m_fail};
            st  = ((k >= hold_lo) && (k <= hold_hi)) || (k == fin_start);
            rst = (k == rst_at);
        end
        st  = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int d8, d12;
        d8  = 4 * (S8 + 1) + 1;
        d12 = 4 * (S12 + 1) + 1;

        repeat (3) @(negedge clk);
        check("reset_dut8",  {if8.a_drv, if8.b_drv, if8.busy, if8.done, if8.pass, if8.fail_mask}, 32'h0);
        check("reset_dut12", {if12.a_drv, if12.b_drv, if12.busy, if12.done, if12.pass, if12.fail_mask}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        mode = 0;
        run(0, -1, -1, -1, -1);
        check("ideal_done_cnt", done_cnt, 1);
        check("ideal_done_cyc", done_cyc, d8);
        check("ideal_busy_first", busy_first, 1);
        check("ideal_busy_last", busy_last, d8);
        check("ideal_busy_cnt", busy_cnt, d8);
        check("ideal_vec_drv", {a_at[0], b_at[0], a_at[1], b_at[1], a_at[2], b_at[2], a_at[3], b_at[3]},
              32'h000FF0FF);
        check("ideal_pass_held", m_pass, 1);
        check("ideal_fail_held", m_fail, 4'b0000);
        check("ideal_drv_idle", {m_a, m_b}, 8'h00);

        mode = 1;
        run(0, -1, -1, -1, -1);
        check("sa0_g2_pass", m_pass, 0);
        check("sa0_g2_fail", m_fail, 4'b0100);

        mode = 2;
        run(0, -1, -1, -1, -1);
        check("sa1_g0_pass", m_pass, 0);
        check("sa1_g0_fail", m_fail, 4'b0001);

        mode = 3;
        run(0, -1, -1, -1, -1);
        check("lag_s8_pass", m_pass, 0);
        check("lag_s8_fail", m_fail, 4'b1000);
        run(1, -1, -1, -1, -1);
        check("lag_s12_done_cyc", done_cyc, d12);
        check("lag_s12_pass", m_pass, 1);
        check("lag_s12_fail", m_fail, 4'b0000);

        mode = 2;
        run(0, -1, -1, 10, -1);
        check("rst_mid_outputs", snap, 16'h0000);
        check("rst_mid_no_done", done_cnt, 0);

        mode = 0;
        run(0, 2, 20, -1, -1);
        check("start_held_done_cnt", done_cnt, 1);
        check("start_held_done_cyc", done_cyc, d8);

        run(0, -1, -1, -1, d8);
        check("start_in_finish_busy_cnt", busy_cnt, d8);
        check("start_in_finish_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hc32_tester.md
HC32_TESTER -- requirements
Module: hc32_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: cycles each test vector is held before its output is sampled; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: run request; accepted only in IDLE.
REQ-005 SHALL have port a_drv, output, 4: A inputs to the four OR gates, bit i = gate i.
REQ-006 SHALL have port b_drv, output, 4: B inputs to the four OR gates.
REQ-007 SHALL have port y_in, input, 4: gate outputs under test, bit i = gate i.
REQ-008 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at end of run.
REQ-010 SHALL have port pass, output, 1: run result, high when no gate failed.
REQ-011 SHALL have port fail_mask, output, 4: sticky per-gate mismatch flags for the current or last run.

Function
REQ-012 SHALL implement states IDLE, SETTLE, CHECK, FINISH; a_drv, b_drv, busy, done, pass and fail_mask SHALL all be registered.
REQ-013 IDLE: a_drv=b_drv=0; start=1 -> SETTLE, vector index v=0, fail_mask cleared, pass cleared, settle counter cleared.
REQ-014 Vector v (2 bits, 0..3) SHALL drive a_drv={4{v[1]}} and b_drv={4{v[0]}}, updated on the edge entering SETTLE for that vector.
REQ-015 SETTLE SHALL last exactly S_EFF cycles (S_EFF=SETTLE_CYCLES, see REQ-028), then -> CHECK.
REQ-016 CHECK (1 cycle): fail_mask <= fail_mask | (y_cmp ^ {4{v[1]|v[0]}}), where y_cmp is y_in (or its synchronized copy) in the CHECK cycle.
REQ-017 CHECK with v<3 -> SETTLE with v+1; CHECK with v=3 -> FINISH; v SHALL NOT wrap within a run.
REQ-018 FINISH (1 cycle): done=1, pass=(final fail_mask==0), a_drv=b_drv=0 from this cycle on; -> IDLE.
REQ-019 Timing: for start high in cycle 0, CHECK of vector k SHALL occur in cycle (k+1)*(S_EFF+1) and done in cycle 4*(S_EFF+1)+1.
REQ-020 pass and fail_mask SHALL hold their values after FINISH until the next accepted start.
REQ-021 start while busy (including the FINISH cycle) SHALL be ignored with no effect on the run in progress.
REQ-022 Settle counter SHALL be 8 bits wide plus enough margin for S_EFF without overflow.

Reset
REQ-023 rst=1 at any clock edge SHALL force IDLE next cycle with a_drv=0, b_drv=0, busy=0, done=0, pass=0, fail_mask=0.
REQ-024 rst SHALL override start in the same cycle.
REQ-025 Reset mid-run SHALL abort the run with no done pulse.
REQ-026 Synchronizer stages, when present, SHALL reset to 0.

Configuration
REQ-027 Macro HC32_SYNC_EN SHALL select a 2-flop synchronizer on y_in.
REQ-028 HC32_SYNC_EN defined: y_cmp = y_in after 2 flops and S_EFF=SETTLE_CYCLES+2. Undefined: y_cmp=y_in, S_EFF=SETTLE_CYCLES, and no synchronizer flops SHALL be present.

Verification (SETTLE_CYCLES=8, HC32_SYNC_EN undefined unless stated)
REQ-029 Ideal model y_in=a_drv|b_drv, start pulse in cycle 0 -> busy high cycles 1..37, done in cycle 37, pass=1, fail_mask=4'b0000.
REQ-030 Gate 2 stuck-at-0 -> pass=0, fail_mask=4'b0100 (mismatches at vectors 1,2,3).
REQ-031 Gate 0 stuck-at-1 -> pass=0, fail_mask=4'b0001 (mismatch at vector 0 only).
REQ-032 Gate 3 output lagging its inputs by 10 cycles -> fail_mask=4'b1000; same model with SETTLE_CYCLES=12 -> pass=1.
REQ-033 rst asserted in cycle 10 of a run -> IDLE with all outputs 0 in cycle 11, no done; start held high during cycles 2..20 of a clean run -> exactly one done.
REQ-034 HC32_SYNC_EN defined, ideal model -> done in cycle 45, pass=1.
